// File: rtl/pattern_loader.sv
`default_nettype none
// ============================================================================
// pattern_loader : loads byte frames (HEADER, N, N data bytes) into the
//                  sequencer's pattern array and zero-fills unused entries.
// Revision       : 1.0
// ============================================================================
module pattern_loader #(
    parameter int         WORD_SIZE      = 8,
    parameter int         ADDRESS_SIZE   = 4,
    parameter int         MEMORY_QTY     = 16,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] HEADER         = 8'hA5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    r_en,
    input  logic [ADDRESS_SIZE-1:0] r_addr,
    output logic [WORD_SIZE-1:0]    r_data,
    output logic                    r_ready,
    output logic                    load_done,
    output logic                    load_error
);

    localparam int               CNT_W     = ADDRESS_SIZE + 1;
    localparam int               GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] QTY       = CNT_W'(MEMORY_QTY);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEMORY_QTY - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_FILL  = 3'd4
    } state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] clr_addr;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [CNT_W-1:0]        frame_len;
    logic [GAP_W-1:0]        gap;
    logic [WORD_SIZE-1:0]    mem [MEMORY_QTY];

    logic                    wr_en;
    logic [ADDRESS_SIZE-1:0] wr_idx;
    logic [WORD_SIZE-1:0]    wr_val;
    logic                    count_ok;
    logic                    last_byte;
    logic                    fill_last;
    logic                    clear_last;
    logic                    gap_expired;
    logic                    unused_r_en;

    assign unused_r_en = r_en;

    assign count_ok    = (int'(in_data) >= 1) && (int'(in_data) <= MEMORY_QTY);
    assign last_byte   = ({1'b0, wr_addr} + CNT_W'(1)) == frame_len;
    assign fill_last   = {1'b0, wr_addr} == LAST_ADDR;
    assign clear_last  = {1'b0, clr_addr} == LAST_ADDR;
    // One idle edge remains before the gap count reaches TIMEOUT_CYCLES.
    assign gap_expired = gap == GAP_LAST;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = wr_addr;
        wr_val = '0;
        case (state)
            S_CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = clr_addr;
            end
            S_DATA: begin
                wr_en  = in_valid;
                wr_val = WORD_SIZE'(in_data);
            end
            S_FILL:  wr_en = 1'b1;
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_val;
        end
    end

    assign r_data = ({1'b0, r_addr} < QTY) ? mem[r_addr] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            wr_addr    <= '0;
            frame_len  <= '0;
            gap        <= '0;
            r_ready    <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (clear_last) begin
                        clr_addr <= '0;
                        state    <= S_IDLE;
                        r_ready  <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (in_valid && (in_data == HEADER)) begin
                        gap     <= '0;
                        state   <= S_COUNT;
                        r_ready <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (in_valid) begin
                        gap <= '0;
                        if (count_ok) begin
                            frame_len <= CNT_W'(in_data);
                            wr_addr   <= '0;
                            state     <= S_DATA;
                        end else begin
                            load_error <= 1'b1;
                            r_ready    <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end else if (gap_expired) begin
                        load_error <= 1'b1;
                        r_ready    <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        gap <= '0;
                        if (last_byte) begin
                            if (frame_len == QTY) begin
                                load_done <= 1'b1;
                                r_ready   <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                wr_addr <= wr_addr + 1'b1;
                                state   <= S_FILL;
                            end
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end else if (gap_expired) begin
                        load_error <= 1'b1;
                        r_ready    <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                S_FILL: begin
                    if (fill_last) begin
                        load_done <= 1'b1;
                        r_ready   <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                default: begin
                    clr_addr <= '0;
                    r_ready  <= 1'b0;
                    state    <= S_CLEAR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pattern_loader.md
# pattern_loader

Byte-framed pattern memory that sits directly upstream of the step sequencer. It receives load frames from a byte source (UART receiver), writes them into a MEMORY_QTY-entry word array, and zero-fills unused entries. The sequencer reads the array through its read port (r_en/r_addr/r_data/r_ready). r_ready is low whenever the array is being cleared or loaded, so the sequencer stalls rather than reading a half-written pattern.

## Interface
- WORD_SIZE, 8: array word width; must equal 8 (one byte per word)
- ADDRESS_SIZE, 4: read/write address width
- MEMORY_QTY, 16: number of entries; 1..2^ADDRESS_SIZE
- TIMEOUT_CYCLES, 65535: maximum clock cycles allowed between bytes inside a frame
- HEADER, 8'hA5: frame start byte

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data valid this cycle (one byte per high cycle)
- in_data  in  8  byte from the upstream receiver
- r_en  in  1  read strobe from the sequencer; no effect on state
- r_addr  in  ADDRESS_SIZE  read address
- r_data  out  WORD_SIZE  mem[r_addr], combinational; 0 when r_addr ≥ MEMORY_QTY
- r_ready  out  1  registered; high only in IDLE
- load_done  out  1  registered one-cycle pulse when a frame completes
- load_error  out  1  registered one-cycle pulse when a frame aborts

## Operation
- Frame format: HEADER, then count N (1..MEMORY_QTY), then N data bytes written to addresses 0..N-1.
- States:
  - CLEAR: entered on reset. Writes 0 to addresses 0..MEMORY_QTY-1, one per cycle, then goes to IDLE.
  - IDLE: ignores in_valid bytes that are not HEADER. On in_valid & in_data==HEADER, goes to COUNT.
  - COUNT: on in_valid, if 1 ≤ in_data ≤ MEMORY_QTY, latches N, sets wr_addr=0 and goes to DATA. Otherwise pulses load_error and returns to IDLE; memory is untouched.
  - DATA: on in_valid, writes mem[wr_addr]<=in_data and increments wr_addr. After the N-th byte: if N==MEMORY_QTY, goes to IDLE and pulses load_done; otherwise goes to FILL.
  - FILL: writes 0 to mem[wr_addr] each cycle, for addresses N..MEMORY_QTY-1, then goes to IDLE and pulses load_done.
- Timeout: a gap counter runs in COUNT and DATA. It clears on in_valid and increments otherwise. When it reaches TIMEOUT_CYCLES, the block pulses load_error and goes to IDLE. Entries already written keep their new values; no fill is performed.
- in_valid during CLEAR or FILL is dropped, including HEADER bytes.
- Reset mid-frame aborts the frame and re-enters CLEAR; no load_done or load_error pulse is produced.
- Width rules:
  - wr_addr and the clear counter are ADDRESS_SIZE wide.
  - The N compare uses at least ADDRESS_SIZE+1 bits, so N==2^ADDRESS_SIZE is legal.
  - The gap counter is sized as clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- During reset: r_ready=0, load_done=0, load_error=0; state=CLEAR with clear counter 0.
- After reset release, CLEAR takes MEMORY_QTY cycles. r_ready rises at the MEMORY_QTY-th rising edge after release.
- r_ready is registered from the next state, so it falls at the same edge that accepts HEADER.
- r_ready and the load_done pulse rise at the edge that performs the last write of a frame: the final data byte, or the final fill write.
- Array writes take effect at the clock edge. r_data shows the new value in the cycle after the write edge.
- Load latency: FILL lasts MEMORY_QTY-N cycles after the last data byte, and is 0 cycles when N==MEMORY_QTY.
- load_error is asserted in the cycle after the bad-count byte, or in the cycle after the counter reaches TIMEOUT_CYCLES. r_ready returns high at the same edge.
- load_done and load_error are never high together.

## Test plan
- Reset: release reset with MEMORY_QTY=16 -> r_ready=0 for 16 cycles, then 1; every r_addr 0..15 reads 0.
- Full load: A5,10,00..0F (16 bytes) -> one load_done pulse, no FILL cycles; mem[i]=i; r_ready low from the A5 edge until the last-byte edge.
- Short load: A5,03,11,22,33 after a full load -> FILL lasts 13 cycles; mem[0..2]=11,22,33; mem[3..15]=0; load_done coincides with r_ready rising.
- Bad count: A5,00 and A5,11 (17) -> load_error pulse for each; memory unchanged; r_ready high in the cycle after each count byte.
- Timeout and noise: with TIMEOUT_CYCLES=8, send stray 3C, then A5,04,AA,BB and stall -> stray byte ignored; load_error 8 cycles after BB; mem[0..1]=AA,BB; mem[2..3] keep old values.
- Reset mid-DATA after 2 of 5 bytes -> no pulse; CLEAR re-runs; all entries 0; r_ready rises 16 cycles after release.
